// File: rtl/acq_peak_detector_if.sv
// Connection bundle between the serial acquisition correlator and the peak detector.
// The correlator raises corr_complete / search_complete as levels; a rising edge marks an event and
// the cell fields stay stable while the level is high. acq_valid is a one-cycle decision strobe with
// no back-pressure; the decision fields remain stable until the next strobe.
interface acq_peak_detector_if #(
  parameter int INT_W = 12,
  parameter int MAG_W = 24
);
  logic                    corr_complete;
  logic                    search_complete;
  logic [INT_W-1:0]        integrator_i;
  logic [INT_W-1:0]        integrator_q;
  logic [9:0]              code_phase;
  logic [4:0]              code_nco_frac;
  logic signed [15:0]      doppler_omega;
  logic [5:0]              sat;

  logic                    acq_valid;
  logic                    acq_found;
  logic [9:0]              peak_code_phase;
  logic [4:0]              peak_code_frac;
  logic signed [15:0]      peak_doppler;
  logic [5:0]              peak_sat;
  logic [MAG_W-1:0]        peak_mag;
  logic [MAG_W-1:0]        second_mag;
  logic [15:0]             corr_count;
  logic                    overrun;
  logic                    busy;

  modport master (
    output corr_complete, search_complete, integrator_i, integrator_q,
           code_phase, code_nco_frac, doppler_omega, sat,
    input  acq_valid, acq_found, peak_code_phase, peak_code_frac, peak_doppler,
           peak_sat, peak_mag, second_mag, corr_count, overrun, busy
  );

  modport slave (
    input  corr_complete, search_complete, integrator_i, integrator_q,
           code_phase, code_nco_frac, doppler_omega, sat,
    output acq_valid, acq_found, peak_code_phase, peak_code_frac, peak_doppler,
           peak_sat, peak_mag, second_mag, corr_count, overrun, busy
  );
endinterface

// File: rtl/acq_peak_detector.sv
// Non-coherent power peak detector: tracks the strongest correlator cell and the best
// non-adjacent competitor, then issues one acquisition decision per search sweep.
module acq_peak_detector #(
  parameter int INT_W    = 12,
  parameter int MAG_W    = 24,
  parameter int RATIO_Q2 = 6,
  parameter int MIN_PEAK = 4096
) (
  input  logic               clk,
  input  logic               rst,
  acq_peak_detector_if.slave bus,
  output logic [2:0]         dbg_state
);
  localparam int CW    = INT_W + 1;
  localparam int SQ_W  = 2 * CW;
  localparam int SUM_W = (SQ_W > MAG_W) ? SQ_W : MAG_W + 1;
  localparam int DW    = MAG_W + 3;
  localparam logic [CW-1:0] MID = CW'(1) << (INT_W - 1);

  typedef enum logic [2:0] {IDLE, COLLECT, DRAIN, DECIDE, REPORT} state_t;
  state_t state;

  logic corr_d, search_d, corr_edge, search_edge;
  logic accept, drop, pipe_busy, pipe_empty;

  // capture stage
  logic                    cap_v;
  logic [INT_W-1:0]        cap_i, cap_q;
  logic [9:0]              cap_ph;
  logic [4:0]              cap_fr;
  logic signed [15:0]      cap_dop;
  logic [5:0]              cap_sat;
  // S1: centred integrators
  logic                    s1_v;
  logic signed [CW-1:0]    s1_ci, s1_cq;
  logic [9:0]              s1_ph;
  logic [4:0]              s1_fr;
  logic signed [15:0]      s1_dop;
  logic [5:0]              s1_sat;
  // S2: squares
  logic                    s2_v;
  logic [SQ_W-1:0]         s2_ii, s2_qq;
  logic [9:0]              s2_ph;
  logic [4:0]              s2_fr;
  logic signed [15:0]      s2_dop;
  logic [5:0]              s2_sat;

  // trackers
  logic [MAG_W-1:0]        pk_mag, sc_mag;
  logic [9:0]              pk_ph;
  logic [4:0]              pk_fr;
  logic signed [15:0]      pk_dop;
  logic [5:0]              trk_sat;
  logic [15:0]             cnt;

  // registered decision outputs
  logic                    acq_valid_r, acq_found_r, overrun_r;
  logic [9:0]              out_ph;
  logic [4:0]              out_fr;
  logic signed [15:0]      out_dop;
  logic [5:0]              out_sat;
  logic [MAG_W-1:0]        out_pk, out_sc;
  logic [15:0]             out_cnt;

  logic signed [SQ_W-1:0]  ci_x, cq_x;
  logic [SUM_W-1:0]        sum;
  logic [MAG_W-1:0]        m_c;
  logic [9:0]              dph;
  logic                    adj, found_c;

  assign corr_edge   = bus.corr_complete & ~corr_d;
  assign search_edge = bus.search_complete & ~search_d;
  assign pipe_busy   = cap_v | s1_v;
  assign pipe_empty  = ~(cap_v | s1_v | s2_v);
  assign accept      = corr_edge & ((state == IDLE) | ((state == COLLECT) & ~pipe_busy));
  assign drop        = corr_edge & ~accept;

  always_comb begin
    ci_x    = SQ_W'(s1_ci);
    cq_x    = SQ_W'(s1_cq);
    sum     = SUM_W'(s2_ii) + SUM_W'(s2_qq);
    m_c     = (sum > SUM_W'({MAG_W{1'b1}})) ? {MAG_W{1'b1}} : sum[MAG_W-1:0];
    // circular code-phase distance over a 1023-chip code: 0 and 1022 are neighbours
    dph     = (s2_ph >= pk_ph) ? (s2_ph - pk_ph) : (pk_ph - s2_ph);
    adj     = (s2_dop == pk_dop) && ((dph <= 10'd1) || (dph == 10'd1022));
    found_c = (cnt != 16'd0) && (pk_mag >= MAG_W'(MIN_PEAK)) &&
              ((DW'(pk_mag) << 2) >= (DW'(sc_mag) * DW'(RATIO_Q2)));
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      corr_d   <= 1'b0;  search_d <= 1'b0;
      cap_v    <= 1'b0;  cap_i    <= '0;  cap_q  <= '0;  cap_ph <= '0;
      cap_fr   <= '0;    cap_dop  <= '0;  cap_sat <= '0;
      s1_v     <= 1'b0;  s1_ci    <= '0;  s1_cq  <= '0;  s1_ph  <= '0;
      s1_fr    <= '0;    s1_dop   <= '0;  s1_sat <= '0;
      s2_v     <= 1'b0;  s2_ii    <= '0;  s2_qq  <= '0;  s2_ph  <= '0;
      s2_fr    <= '0;    s2_dop   <= '0;  s2_sat <= '0;
    end else begin
      corr_d   <= bus.corr_complete;
      search_d <= bus.search_complete;
      cap_v    <= accept;
      if (accept) begin
        cap_i   <= bus.integrator_i;
        cap_q   <= bus.integrator_q;
        cap_ph  <= bus.code_phase;
        cap_fr  <= bus.code_nco_frac;
        cap_dop <= bus.doppler_omega;
        cap_sat <= bus.sat;
      end
      s1_v <= cap_v;
      if (cap_v) begin
        s1_ci  <= $signed({1'b0, cap_i} - MID);
        s1_cq  <= $signed({1'b0, cap_q} - MID);
        s1_ph  <= cap_ph;  s1_fr  <= cap_fr;
        s1_dop <= cap_dop; s1_sat <= cap_sat;
      end
      s2_v <= s1_v;
      if (s1_v) begin
        s2_ii  <= ci_x * ci_x;
        s2_qq  <= cq_x * cq_x;
        s2_ph  <= s1_ph;  s2_fr  <= s1_fr;
        s2_dop <= s1_dop; s2_sat <= s1_sat;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      pk_mag      <= '0;  sc_mag <= '0;  pk_ph <= '0;  pk_fr <= '0;
      pk_dop      <= '0;  trk_sat <= '0; cnt   <= '0;
      acq_valid_r <= 1'b0; acq_found_r <= 1'b0; overrun_r <= 1'b0;
      out_ph      <= '0;  out_fr <= '0;  out_dop <= '0; out_sat <= '0;
      out_pk      <= '0;  out_sc <= '0;  out_cnt <= '0;
    end else begin
      if (s2_v) begin
        if (m_c > pk_mag) begin
          if (!adj) sc_mag <= pk_mag;
          pk_mag <= m_c;  pk_ph  <= s2_ph;
          pk_fr  <= s2_fr; pk_dop <= s2_dop;
        end else if ((m_c > sc_mag) && !adj) begin
          sc_mag <= m_c;
        end
        trk_sat <= s2_sat;
        if (cnt != 16'hFFFF) cnt <= cnt + 16'd1;
      end
      if (drop) overrun_r <= 1'b1;

      case (state)
        IDLE: begin
          if (corr_edge) begin
            cnt       <= '0;
            overrun_r <= 1'b0;
            state     <= search_edge ? DRAIN : COLLECT;
          end else if (search_edge) begin
            state <= DRAIN;
          end
        end
        COLLECT: if (search_edge) state <= DRAIN;
        DRAIN:   if (pipe_empty) state <= DECIDE;
        DECIDE: begin
          acq_valid_r <= 1'b1;
          acq_found_r <= found_c;
          out_ph      <= pk_ph;   out_fr  <= pk_fr;
          out_dop     <= pk_dop;  out_sat <= trk_sat;
          out_pk      <= pk_mag;  out_sc  <= sc_mag;
          out_cnt     <= cnt;
          state       <= REPORT;
        end
        REPORT: begin
          acq_valid_r <= 1'b0;
          pk_mag <= '0;  sc_mag  <= '0;  pk_ph <= '0;  pk_fr <= '0;
          pk_dop <= '0;  trk_sat <= '0;  cnt   <= '0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.acq_valid       = acq_valid_r;
  assign bus.acq_found       = acq_found_r;
  assign bus.peak_code_phase = out_ph;
  assign bus.peak_code_frac  = out_fr;
  assign bus.peak_doppler    = out_dop;
  assign bus.peak_sat        = out_sat;
  assign bus.peak_mag        = out_pk;
  assign bus.second_mag      = out_sc;
  assign bus.corr_count      = out_cnt;
  assign bus.overrun         = overrun_r;
  assign bus.busy            = (state != IDLE);
  assign dbg_state           = state;
endmodule
